// File: rtl/seg_scan_controller_if.sv
// Display-side bundle: scan enable, frame data in, anode/segment drive out.
// Latency: none (wires only).
// Backpressure: none; the display consumes one digit slot per dwell period.
// Ports: en, digits[31:0], digit_mask, blink_mask, dp, lz_en  (master -> slave)
//        AN, SEG, frame_start, blink_phase                     (slave -> master)
interface seg_scan_controller_if;
    logic        en;
    logic [31:0] digits;
    logic [7:0]  digit_mask;
    logic [7:0]  blink_mask;
    logic [7:0]  dp;
    logic        lz_en;
    logic [7:0]  AN;
    logic [7:0]  SEG;
    logic        frame_start;
    logic        blink_phase;

    modport master (
        output en, digits, digit_mask, blink_mask, dp, lz_en,
        input  AN, SEG, frame_start, blink_phase
    );

    modport slave (
        input  en, digits, digit_mask, blink_mask, dp, lz_en,
        output AN, SEG, frame_start, blink_phase
    );
endinterface

// File: rtl/seg_scan_controller.sv
// 8-digit common-anode 7-seg scanner: blank slot + dwell slot per digit, per-frame snapshot.
// Latency: AN/SEG registered with the state, valid in the same cycle as the state they describe.
// Backpressure: none; en=0 parks the sequencer (dark), en rising restarts at digit 0.
// Ports: clk1000Hz (scan clock), rst_n (async active-low), bus (slave modport of
//        seg_scan_controller_if: display data/controls in, AN/SEG/frame_start/blink_phase out).
module seg_scan_controller #(
    parameter int BLANK_CYC    = 1,
    parameter int DWELL_CYC    = 1,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                   clk1000Hz,
    input  logic                   rst_n,
    seg_scan_controller_if.slave   bus
);
    localparam int CMAX = (BLANK_CYC > DWELL_CYC) ? BLANK_CYC : DWELL_CYC;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int FW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            park_q, park_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic            bp_q, bp_d;
    logic [7:0]      an_q, an_d;
    logic [7:0]      seg_q, seg_d;
    logic            fs_q, fs_d;
    logic            snap_en;

    logic [31:0]     snap_dig_q;
    logic [7:0]      snap_mask_q, snap_blink_q, snap_dp_q, lzsup_q;
    logic [7:0]      lzsup_d;

    logic [3:0]      cur_dig;
    logic            cur_vis;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
        endcase
    endfunction

    // Leading zeros from the live inputs; only latched when a snapshot is taken.
    // Digit 0 is excluded so an all-zero value still shows a single "0".
    always_comb begin
        logic zero_run;
        lzsup_d  = '0;
        zero_run = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            zero_run   = zero_run & (bus.digits[i*4 +: 4] == 4'h0);
            lzsup_d[i] = bus.lz_en & zero_run;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        park_d  = park_q;
        fcnt_d  = fcnt_q;
        bp_d    = bp_q;
        fs_d    = 1'b0;
        snap_en = 1'b0;
        an_d    = 8'hFF;
        seg_d   = 8'hFF;
        cur_dig = '0;
        cur_vis = 1'b0;

        if (!bus.en) begin
            state_d = ST_BLANK;
            idx_d   = '0;
            cnt_d   = '0;
            park_d  = 1'b1;
        end else if (park_q) begin
            // Leaving reset/park: start a fresh frame without counting a wrap.
            state_d = ST_BLANK;
            idx_d   = '0;
            cnt_d   = '0;
            park_d  = 1'b0;
            snap_en = 1'b1;
            fs_d    = 1'b1;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == CW'(BLANK_CYC - 1)) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (cnt_q == CW'(DWELL_CYC - 1)) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        idx_d   = idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            snap_en = 1'b1;
                            fs_d    = 1'b1;
                            if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
                                fcnt_d = '0;
                                bp_d   = ~bp_q;
                            end else begin
                                fcnt_d = fcnt_q + 1'b1;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end

        // Snapshot and blink phase only move on BLANK entry, so current values
        // are the right ones whenever the next state is SHOW.
        if (state_d == ST_SHOW) begin
            cur_dig = snap_dig_q[idx_d*4 +: 4];
            cur_vis = snap_mask_q[idx_d] & ~(snap_blink_q[idx_d] & bp_q) & ~lzsup_q[idx_d];
            if (cur_vis) begin
                an_d  = ~(8'd1 << idx_d);
                seg_d = {~snap_dp_q[idx_d], seg7(cur_dig)};
            end
        end
    end

    always_ff @(posedge clk1000Hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BLANK;
            idx_q   <= '0;
            cnt_q   <= '0;
            park_q  <= 1'b1;
            fcnt_q  <= '0;
            bp_q    <= 1'b0;
            an_q    <= 8'hFF;
            seg_q   <= 8'hFF;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            park_q  <= park_d;
            fcnt_q  <= fcnt_d;
            bp_q    <= bp_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            fs_q    <= fs_d;
        end
    end

    always_ff @(posedge clk1000Hz or negedge rst_n) begin
        if (!rst_n) begin
            snap_dig_q   <= '0;
            snap_mask_q  <= '0;
            snap_blink_q <= '0;
            snap_dp_q    <= '0;
            lzsup_q      <= '0;
        end else if (snap_en) begin
            snap_dig_q   <= bus.digits;
            snap_mask_q  <= bus.digit_mask;
            snap_blink_q <= bus.blink_mask;
            snap_dp_q    <= bus.dp;
            lzsup_q      <= lzsup_d;
        end
    end

    assign bus.AN          = an_q;
    assign bus.SEG         = seg_q;
    assign bus.frame_start = fs_q;
    assign bus.blink_phase = bp_q;
endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller: reset, scan order, lz, blink, snapshot, en, masks.
// Latency: outputs sampled on the falling edge, half a cycle after the registering edge.
// Backpressure: n/a; the bench drives inputs on falling edges.
module tb_seg_scan_controller;
    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    localparam logic [6:0] DEC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg_scan_controller_if bus ();

    seg_scan_controller #(
        .BLANK_CYC    (1),
        .DWELL_CYC    (1),
        .BLINK_FRAMES (2)
    ) dut (
        .clk1000Hz (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks ncyc cycles of a frame starting at its first BLANK cycle.
    // ed/ev/edp: digits, visibility and dp expected for this frame's snapshot.
    task automatic run_frame(input string name, input logic [31:0] ed, input logic [7:0] ev,
                             input logic [7:0] edp, input logic ebp, input int ncyc,
                             input int chg_at, input logic [31:0] chg_val);
        for (int c = 0; c < ncyc; c++) begin
            int         d;
            logic [7:0] an_e, seg_e;
            @(negedge clk);
            d = c / 2;
            if (c % 2 == 0) begin
                chk($sformatf("%s c%0d fs", name, c), {7'd0, bus.frame_start}, {7'd0, c == 0});
                chk($sformatf("%s c%0d blank AN", name, c), bus.AN, 8'hFF);
                chk($sformatf("%s c%0d blank SEG", name, c), bus.SEG, 8'hFF);
                if (c == 0)
                    chk($sformatf("%s bp", name), {7'd0, bus.blink_phase}, {7'd0, ebp});
            end else begin
                an_e  = ev[d] ? ~(8'd1 << d) : 8'hFF;
                seg_e = ev[d] ? {~edp[d], DEC[ed[d*4 +: 4]]} : 8'hFF;
                chk($sformatf("%s d%0d AN", name, d), bus.AN, an_e);
                chk($sformatf("%s d%0d SEG", name, d), bus.SEG, seg_e);
                chk($sformatf("%s d%0d fs", name, d), {7'd0, bus.frame_start}, 8'd0);
            end
            if (c == chg_at) bus.digits = chg_val;
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.en         = 1'b1;
        bus.digits     = 32'h12345678;
        bus.digit_mask = 8'hFF;
        bus.blink_mask = 8'h01;
        bus.dp         = 8'h00;
        bus.lz_en      = 1'b0;

        // T1: reset state
        repeat (3) @(negedge clk);
        chk("rst AN", bus.AN, 8'hFF);
        chk("rst SEG", bus.SEG, 8'hFF);
        chk("rst fs", {7'd0, bus.frame_start}, 8'd0);
        chk("rst bp", {7'd0, bus.blink_phase}, 8'd0);
        rst_n = 1'b1;

        // T2 + T4: scan order; digit 0 blinks with a 2-frame half-period
        run_frame("f0", 32'h12345678, 8'hFF, 8'h00, 1'b0, 16, -1, '0);
        run_frame("f1", 32'h12345678, 8'hFF, 8'h00, 1'b0, 16, -1, '0);
        run_frame("f2", 32'h12345678, 8'hFE, 8'h00, 1'b1, 16, -1, '0);
        run_frame("f3", 32'h12345678, 8'hFE, 8'h00, 1'b1, 16, -1, '0);
        run_frame("f4", 32'h12345678, 8'hFF, 8'h00, 1'b0, 16, -1, '0);

        // T3: leading-zero suppression
        bus.digits     = 32'h00000305;
        bus.lz_en      = 1'b1;
        bus.blink_mask = 8'h00;
        run_frame("lz", 32'h00000305, 8'h07, 8'h00, 1'b0, 16, -1, '0);

        // T6: digit mask and decimal point
        bus.digits     = 32'h12345678;
        bus.lz_en      = 1'b0;
        bus.digit_mask = 8'hF0;
        bus.dp         = 8'h10;
        run_frame("mask", 32'h12345678, 8'hF0, 8'h10, 1'b1, 16, -1, '0);

        // T5: mid-frame input change is held off until the next snapshot
        bus.digit_mask = 8'hFF;
        bus.dp         = 8'h00;
        run_frame("snap", 32'h12345678, 8'hFF, 8'h00, 1'b1, 16, 4, 32'h87654321);
        run_frame("snap2", 32'h87654321, 8'hFF, 8'h00, 1'b0, 8, -1, '0);

        // en drop during SHOW of digit 3
        bus.en = 1'b0;
        @(negedge clk);
        chk("en0 AN", bus.AN, 8'hFF);
        chk("en0 SEG", bus.SEG, 8'hFF);
        chk("en0 fs", {7'd0, bus.frame_start}, 8'd0);
        repeat (3) @(negedge clk);
        chk("en0 AN hold", bus.AN, 8'hFF);
        chk("en0 bp hold", {7'd0, bus.blink_phase}, 8'd0);
        bus.en = 1'b1;
        run_frame("en1", 32'h87654321, 8'hFF, 8'h00, 1'b0, 16, -1, '0);
        run_frame("f10", 32'h87654321, 8'hFF, 8'h00, 1'b0, 16, -1, '0);
        run_frame("f11", 32'h87654321, 8'hFF, 8'h00, 1'b1, 4, -1, '0);

        // async reset mid-frame while digit 1 is lit and blink phase is 1
        #2 rst_n = 1'b0;
        #1;
        chk("arst AN", bus.AN, 8'hFF);
        chk("arst SEG", bus.SEG, 8'hFF);
        chk("arst bp", {7'd0, bus.blink_phase}, 8'd0);
        chk("arst fs", {7'd0, bus.frame_start}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame("post", 32'h87654321, 8'hFF, 8'h00, 1'b0, 4, -1, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
